// File: rtl/fetch_queue_pkg.sv
// Shared CPU definitions for the fetch/decode boundary.
// Holds the queue entry layout and front-end defaults.
package fetch_queue_pkg;

  localparam int          FQ_DEPTH    = 4;
  localparam logic [31:0] FQ_NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] PC;
    logic [31:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: circular buffer between fetch and decode.
// Flush from execute empties it; head read is combinational.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = FQ_DEPTH,
  parameter logic [31:0] NOP_INST = FQ_NOP_INST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_FQ_valid,
  input  logic [31:0]              i_FQ_PC,
  input  logic [31:0]              i_FQ_inst,
  output logic                     o_FQ_ready,
  input  logic                     i_FQ_pause,
  input  logic                     i_FQ_flush,
  output logic                     o_FQ_valid,
  output logic [31:0]              o_FQ_PC,
  output logic [31:0]              o_FQ_inst,
  output logic [$clog2(DEPTH):0]   o_FQ_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t       mem_q [DEPTH];
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push, pop;
  fq_entry_t       head;

  assign o_FQ_ready = (cnt_q != CW'(DEPTH));
  assign o_FQ_valid = (cnt_q != '0);
  assign o_FQ_count = cnt_q;

  assign push = i_FQ_valid & o_FQ_ready & ~i_FQ_flush;
  assign pop  = o_FQ_valid & ~i_FQ_pause & ~i_FQ_flush;

  assign head      = mem_q[rd_q];
  assign o_FQ_PC   = o_FQ_valid ? head.PC   : 32'h0;
  assign o_FQ_inst = o_FQ_valid ? head.inst : NOP_INST;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (i_FQ_flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      if (push && !pop)
        cnt_d = cnt_q + CW'(1);
      else if (pop && !push)
        cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is unreset; invalid slots are masked at the outputs.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= '{PC: i_FQ_PC, inst: i_FQ_inst};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue with a queue-based model.
// Random and directed traffic; monitor checks every negedge.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_pause, i_flush;
  logic [31:0] i_pc, i_inst;
  logic        o_ready, o_valid;
  logic [31:0] o_pc, o_inst;
  logic [2:0]  o_count;

  int n_cmp = 0;
  int n_err = 0;

  fq_entry_t mq[$];
  fq_entry_t exp_q[$];

  fetch_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_FQ_valid (i_valid),
    .i_FQ_PC    (i_pc),
    .i_FQ_inst  (i_inst),
    .o_FQ_ready (o_ready),
    .i_FQ_pause (i_pause),
    .i_FQ_flush (i_flush),
    .o_FQ_valid (o_valid),
    .o_FQ_PC    (o_pc),
    .o_FQ_inst  (o_inst),
    .o_FQ_count (o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a bounded FIFO updated at each edge.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      exp_q.delete();
    end else if (i_flush) begin
      mq.delete();
      exp_q.delete();
    end else begin
      bit can_push;
      can_push = (mq.size() != DEPTH);
      if (mq.size() != 0 && !i_pause) void'(mq.pop_front());
      if (i_valid && can_push) begin
        mq.push_back('{PC: i_pc, inst: i_inst});
        exp_q.push_back('{PC: i_pc, inst: i_inst});
      end
    end
  end

  // Monitor: state checks plus scoreboard pop on each consume.
  initial forever begin
    @(negedge clk);
    chk("count", 64'(o_count), 64'(mq.size()));
    chk("ready", 64'(o_ready), 64'(mq.size() != DEPTH));
    chk("valid", 64'(o_valid), 64'(mq.size() != 0));
    if (!o_valid) begin
      chk("idle_pc", 64'(o_pc), 64'h0);
      chk("idle_inst", 64'(o_inst), 64'(NOP));
    end else if (!i_pause && !i_flush && !rst) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'(o_pc), 64'hFFFF_FFFF);
      end else begin
        fq_entry_t e;
        e = exp_q.pop_front();
        chk("sb_pc", 64'(o_pc), 64'(e.PC));
        chk("sb_inst", 64'(o_inst), 64'(e.inst));
      end
    end
  end

  task automatic cyc(input logic v, input logic [31:0] pc,
                     input logic ps, input logic fl);
    i_valid = v;
    i_pc    = pc;
    i_inst  = $urandom;
    i_pause = ps;
    i_flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    i_valid = 0; i_pause = 0; i_flush = 0;
    i_pc = 0; i_inst = 0;
    #2;
    chk("rst_valid", 64'(o_valid), 64'h0);
    chk("rst_ready", 64'(o_ready), 64'h1);
    chk("rst_count", 64'(o_count), 64'h0);
    chk("rst_inst", 64'(o_inst), 64'(NOP));
    chk("rst_pc", 64'(o_pc), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill while paused, then a dropped fifth push.
    for (int k = 0; k < 4; k++) cyc(1, 32'(k * 4), 1, 0);
    chk("full_count", 64'(o_count), 64'd4);
    chk("full_ready", 64'(o_ready), 64'h0);
    chk("full_head", 64'(o_pc), 64'h0);
    cyc(1, 32'h10, 1, 0);
    chk("drop_count", 64'(o_count), 64'd4);

    // Drain in order, no pushes.
    for (int k = 0; k < 4; k++) begin
      chk("drain_head", 64'(o_pc), 64'(k * 4));
      cyc(0, 0, 0, 0);
    end
    chk("drain_valid", 64'(o_valid), 64'h0);
    chk("drain_inst", 64'(o_inst), 64'(NOP));

    // Steady push+pop across pointer wrap.
    for (int k = 0; k < 10; k++) begin
      cyc(1, 32'h100 + 32'(k * 4), 0, 0);
      chk("steady_count", 64'(o_count), 64'd1);
      chk("steady_head", 64'(o_pc), 64'(32'h100 + 32'(k * 4)));
    end
    cyc(0, 0, 0, 0);

    // Flush with a same-cycle push.
    for (int k = 0; k < 3; k++) cyc(1, 32'h200 + 32'(k * 4), 1, 0);
    chk("pre_flush", 64'(o_count), 64'd3);
    cyc(1, 32'h40, 0, 1);
    chk("flush_count", 64'(o_count), 64'd0);
    chk("flush_valid", 64'(o_valid), 64'h0);
    cyc(0, 0, 0, 0);
    chk("flush_drop", 64'(o_valid), 64'h0);

    // Flush while paused and full.
    for (int k = 0; k < 4; k++) cyc(1, 32'h300 + 32'(k * 4), 1, 0);
    cyc(0, 0, 1, 1);
    chk("pflush_count", 64'(o_count), 64'd0);

    // Asynchronous reset between edges.
    cyc(1, 32'h500, 1, 0);
    cyc(1, 32'h504, 1, 0);
    i_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(o_valid), 64'h0);
    chk("arst_count", 64'(o_count), 64'h0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    cyc(1, 32'h80, 0, 0);
    chk("post_rst_valid", 64'(o_valid), 64'h1);
    chk("post_rst_pc", 64'(o_pc), 64'h80);
    cyc(0, 0, 0, 0);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      cyc($urandom_range(0, 9) < 7, {$urandom_range(0, 65535), 2'b00},
          $urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0);
    end
    for (int k = 0; k < DEPTH + 2; k++) cyc(0, 0, 0, 0);
    chk("sb_empty", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
